// File: rtl/param_P.sv
// Shared widths for the MAC stage and its downstream frame accumulator.
//   P       : MAC operand width; a MAC result is 2*P bits wide.
//   ACC_N   : default number of MAC results summed into one frame.
//   acc_w() : accumulator width that holds n results of 2*p bits without wrap.
//   fp_w()  : width of a frame position counter for n samples (at least 1 bit).
//   slot_state_e : states of the single-entry output holding register.
package param_P;

    localparam int P     = 8;
    localparam int ACC_N = 4;

    // n * (2^(2p) - 1) < n * 2^(2p) <= 2^(2p + clog2(n)), so clog2(n) extra
    // bits always cover the largest possible frame total.
    function automatic int acc_w(input int p, input int n);
        return 2 * p + $clog2(n);
    endfunction

    function automatic int fp_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/acc_out_slot.sv
// Single-entry valid/ready holding register for completed frame totals.
//   clk, rst_n  : clock and asynchronous active-low reset.
//   clear       : synchronous flush of the held total and the overrun flag.
//   load        : a frame completed this cycle; load_data is its total.
//   out_ready   : consumer accepts out_sum this cycle.
//   out_valid   : out_sum holds an unconsumed total.
//   out_sum     : held total, stable while out_valid and not accepted.
//   overrun     : sticky, set when a completion arrives while the slot is
//                 full and not being drained.
module acc_out_slot
    import param_P::*;
#(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_sum,
    output logic         overrun
);

    slot_state_e  state_q, state_d;
    logic [W-1:0] sum_q, sum_d;
    logic         ovr_q, ovr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
            sum_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        ovr_d   = ovr_q;
        if (clear) begin
            state_d = SLOT_EMPTY;
            sum_d   = '0;
            ovr_d   = 1'b0;
        end else begin
            case (state_q)
                SLOT_EMPTY: begin
                    if (load) begin
                        state_d = SLOT_FULL;
                        sum_d   = load_data;
                    end
                end
                SLOT_FULL: begin
                    if (out_ready) begin
                        // Drain and refill in the same cycle keeps the slot full.
                        if (load) begin
                            sum_d = load_data;
                        end else begin
                            state_d = SLOT_EMPTY;
                        end
                    end else if (load) begin
                        // Slot is stalled: the older total wins, the new one is lost.
                        ovr_d = 1'b1;
                    end
                end
                default: state_d = SLOT_EMPTY;
            endcase
        end
    end

    assign out_valid = (state_q == SLOT_FULL);
    assign out_sum   = sum_q;
    assign overrun   = ovr_q;

endmodule

// File: rtl/mac_frame_acc.sv
// Sums N consecutive valid MAC results (2*P bits, unsigned) into one frame
// total and presents it on a valid/ready output.
//   clk, rst_n         : clock and asynchronous active-low reset.
//   in_valid, in_data  : one MAC result per cycle when in_valid is high.
//   clear              : synchronous flush of the frame, output slot and overrun.
//   out_valid, out_ready, out_sum : frame total handshake.
//   overrun            : sticky flag, a completed frame was dropped.
//   frame_pos          : samples already accumulated in the current frame.
module mac_frame_acc
    import param_P::*;
#(
    parameter int P_W   = P,
    parameter int N     = ACC_N,
    localparam int IN_W  = 2 * P_W,
    localparam int ACC_W = acc_w(P_W, N),
    localparam int FP_W  = fp_w(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             overrun,
    output logic [FP_W-1:0]  frame_pos
);

    localparam logic [FP_W-1:0] LAST_POS = FP_W'(N - 1);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [FP_W-1:0]  pos_q, pos_d;
    logic [ACC_W-1:0] sum_next;
    logic             complete;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            pos_q <= '0;
        end else begin
            acc_q <= acc_d;
            pos_q <= pos_d;
        end
    end

    always_comb begin
        // The first sample of a frame starts fresh, so acc need not be
        // cleared on completion.
        sum_next = (pos_q == '0) ? ACC_W'(in_data) : acc_q + ACC_W'(in_data);
        complete = in_valid && !clear && (pos_q == LAST_POS);
        acc_d    = acc_q;
        pos_d    = pos_q;
        if (clear) begin
            acc_d = '0;
            pos_d = '0;
        end else if (in_valid) begin
            if (complete) begin
                pos_d = '0;
            end else begin
                acc_d = sum_next;
                pos_d = pos_q + 1'b1;
            end
        end
    end

    assign frame_pos = pos_q;

    acc_out_slot #(
        .W(ACC_W)
    ) u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .load      (complete),
        .load_data (sum_next),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_sum   (out_sum),
        .overrun   (overrun)
    );

endmodule

// File: tb/tb_mac_frame_acc.sv
// Directed testbench for mac_frame_acc (P=8, N=4, 18-bit totals).
module tb_mac_frame_acc;
    import param_P::*;

    localparam int IN_W  = 2 * P;
    localparam int ACC_W = acc_w(P, ACC_N);
    localparam int FP_W  = fp_w(ACC_N);

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [IN_W-1:0]  in_data;
    logic             clear;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             overrun;
    logic [FP_W-1:0]  frame_pos;

    int checks_cnt   = 0;
    int failures_cnt = 0;

    mac_frame_acc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .overrun   (overrun),
        .frame_pos (frame_pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            failures_cnt++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    // One clock cycle: inputs applied on the falling edge, outputs observable
    // #1 after the following rising edge.
    task automatic step(input logic v, input int d, input logic rdy, input logic clr);
        @(negedge clk);
        in_valid  = v;
        in_data   = IN_W'(d);
        out_ready = rdy;
        clear     = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic frame4(input int a, input int b, input int c, input int d, input logic rdy);
        step(1'b1, a, rdy, 1'b0);
        step(1'b1, b, rdy, 1'b0);
        step(1'b1, c, rdy, 1'b0);
        step(1'b1, d, rdy, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; clear = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_out_valid", 32'(out_valid), 0);
        check_val("rst_overrun", 32'(overrun), 0);
        check_val("rst_frame_pos", 32'(frame_pos), 0);
        check_val("rst_out_sum", 32'(out_sum), 0);
        @(negedge clk); rst_n = 1'b1;

        // 1: reset mid-frame discards the partial sum
        step(1'b1, 5, 1'b1, 1'b0);
        step(1'b1, 5, 1'b1, 1'b0);
        check_val("t1_pos_before_rst", 32'(frame_pos), 2);
        @(negedge clk); in_valid = 1'b0; rst_n = 1'b0;
        #1;
        check_val("t1_async_pos", 32'(frame_pos), 0);
        check_val("t1_async_valid", 32'(out_valid), 0);
        check_val("t1_async_overrun", 32'(overrun), 0);
        @(negedge clk); rst_n = 1'b1;
        frame4(1, 1, 1, 1, 1'b1);
        check_val("t1_sum", 32'(out_sum), 4);
        check_val("t1_valid", 32'(out_valid), 1);
        step(1'b0, 0, 1'b1, 1'b0);
        check_val("t1_accepted", 32'(out_valid), 0);

        // 2: back-to-back frame
        step(1'b1, 100, 1'b1, 1'b0);
        step(1'b1, 200, 1'b1, 1'b0);
        step(1'b1, 300, 1'b1, 1'b0);
        check_val("t2_valid_early", 32'(out_valid), 0);
        step(1'b1, 400, 1'b1, 1'b0);
        check_val("t2_valid", 32'(out_valid), 1);
        check_val("t2_sum", 32'(out_sum), 1000);
        check_val("t2_pos", 32'(frame_pos), 0);
        step(1'b0, 0, 1'b1, 1'b0);
        check_val("t2_accepted", 32'(out_valid), 0);

        // 3: gaps of 3 idle cycles between samples
        step(1'b1, 100, 1'b1, 1'b0);
        check_val("t3_pos1", 32'(frame_pos), 1);
        repeat (3) step(1'b0, 77, 1'b1, 1'b0);
        check_val("t3_pos1_hold", 32'(frame_pos), 1);
        step(1'b1, 200, 1'b1, 1'b0);
        check_val("t3_pos2", 32'(frame_pos), 2);
        repeat (3) step(1'b0, 77, 1'b1, 1'b0);
        step(1'b1, 300, 1'b1, 1'b0);
        check_val("t3_pos3", 32'(frame_pos), 3);
        repeat (3) step(1'b0, 77, 1'b1, 1'b0);
        check_val("t3_valid_early", 32'(out_valid), 0);
        step(1'b1, 400, 1'b1, 1'b0);
        check_val("t3_pos0", 32'(frame_pos), 0);
        check_val("t3_sum", 32'(out_sum), 1000);
        check_val("t3_valid", 32'(out_valid), 1);
        step(1'b0, 0, 1'b1, 1'b0);

        // 4: stalled output drops the second frame
        frame4(10, 10, 10, 10, 1'b0);
        check_val("t4_sum_first", 32'(out_sum), 40);
        check_val("t4_no_ovr_yet", 32'(overrun), 0);
        frame4(20, 20, 20, 20, 1'b0);
        check_val("t4_sum_held", 32'(out_sum), 40);
        check_val("t4_valid_held", 32'(out_valid), 1);
        check_val("t4_overrun", 32'(overrun), 1);
        step(1'b0, 0, 1'b1, 1'b0);
        check_val("t4_drained", 32'(out_valid), 0);
        check_val("t4_ovr_sticky", 32'(overrun), 1);
        step(1'b0, 0, 1'b1, 1'b0);
        check_val("t4_ready_empty", 32'(out_valid), 0);
        step(1'b0, 0, 1'b0, 1'b1);
        check_val("t4_ovr_cleared", 32'(overrun), 0);

        // 5: drain and refill in the same cycle
        frame4(5, 5, 5, 5, 1'b0);
        check_val("t5_sum_first", 32'(out_sum), 20);
        step(1'b1, 7, 1'b0, 1'b0);
        step(1'b1, 7, 1'b0, 1'b0);
        step(1'b1, 7, 1'b0, 1'b0);
        step(1'b1, 7, 1'b1, 1'b0);
        check_val("t5_valid", 32'(out_valid), 1);
        check_val("t5_sum", 32'(out_sum), 28);
        check_val("t5_overrun", 32'(overrun), 0);
        step(1'b0, 0, 1'b1, 1'b0);
        check_val("t5_drained", 32'(out_valid), 0);

        // 6: full-scale inputs, then clear overriding a sample
        frame4(65535, 65535, 65535, 65535, 1'b1);
        check_val("t6_max_sum", 32'(out_sum), 262140);
        check_val("t6_max_valid", 32'(out_valid), 1);
        step(1'b0, 0, 1'b1, 1'b0);
        step(1'b1, 3, 1'b1, 1'b0);
        check_val("t6_pos1", 32'(frame_pos), 1);
        step(1'b1, 9, 1'b1, 1'b1);
        check_val("t6_clear_pos", 32'(frame_pos), 0);
        check_val("t6_clear_valid", 32'(out_valid), 0);
        frame4(2, 2, 2, 2, 1'b1);
        check_val("t6_after_clear_sum", 32'(out_sum), 8);
        check_val("t6_after_clear_valid", 32'(out_valid), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
        $finish;
    end

endmodule
